arb_alu: RTL and testbench
==========================

ARB_ALU -- requirements
Module: arb_alu

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4, the number of request sources (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 4, the operand/result width in bits (2..32).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; all state updates on the rising edge of clk.
REQ-004 Port clk  input  1  system clock.
REQ-005 Port rst_n  input  1  synchronous active-low reset.
REQ-006 Port src_valid  input  N_SRC  bit i set = source i offers a transaction.
REQ-007 Port src_op  input  2*N_SRC  opcode of source i at bits [2i+1:2i].
REQ-008 Port src_data  input  DATA_W*N_SRC  operand of source i at slice i.
REQ-009 Port src_ready  output  N_SRC  bit i set = source i transaction accepted this cycle.
REQ-010 Port out_valid  output  1  result register holds a valid result.
REQ-011 Port out_data  output  DATA_W  result value.
REQ-012 Port out_src  output  max(1,$clog2(N_SRC))  index of the source that produced out_data.
REQ-013 Port out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-014 A transfer on source i SHALL occur when src_valid[i] and src_ready[i] are both 1 at a clock edge.
REQ-015 The output stage SHALL be in state EMPTY when out_valid=0 and FULL when out_valid=1.
REQ-016 Signal can_load SHALL be (out_valid==0) or (out_ready==1).
REQ-017 At most one src_ready bit SHALL be 1 per cycle, namely the granted source when can_load=1; all bits 0 otherwise.
REQ-018 src_ready SHALL be combinational from src_valid, the priority state and can_load, never from src_op or src_data.
REQ-019 Without round-robin, grant SHALL go to the highest-index source with src_valid set.
REQ-020 Opcode 00 SHALL produce result 0; 01 SHALL produce operand AND mask, where mask bit k = k mod 2.
REQ-021 Opcode 10 SHALL produce (operand + 3) mod 2^DATA_W; 11 SHALL produce (operand << 2) truncated to DATA_W bits.
REQ-022 On a transfer, out_data, out_src and out_valid=1 SHALL load at that edge, giving one-cycle latency.
REQ-023 With can_load=1 and no source valid, out_valid SHALL go to 0 at the edge; out_data and out_src hold.
REQ-024 In FULL with out_ready=0, out_valid, out_data and out_src SHALL hold unchanged.
REQ-025 In FULL with out_ready=1 and a valid source, the result SHALL be consumed and replaced at the same edge, sustaining one transfer per cycle.

Reset
REQ-026 While rst_n=0 at an edge, out_valid, out_data and out_src SHALL become 0 and the round-robin pointer SHALL become N_SRC-1.
REQ-027 src_ready SHALL be all 0 in any cycle where rst_n=0.
REQ-028 Reset asserted while out_valid=1 SHALL discard the held result with no transfer reported.

Configuration
REQ-029 With macro ARB_ALU_RR_EN defined, grant SHALL search ascending from (last_grant+1) mod N_SRC with wrap-around.
REQ-030 With ARB_ALU_RR_EN defined, last_grant SHALL update only on a transfer.
REQ-031 Without ARB_ALU_RR_EN, no pointer register SHALL exist and fixed priority (REQ-019) SHALL apply.

Structure
REQ-032 Opcode encodings (OP_NOP, OP_AND, OP_ADD3, OP_SHL2) SHALL be constants in the shared package arb_alu_pkg.
REQ-033 Grant selection (fixed or round-robin) SHALL be in the sub-module arb_alu_arbiter; the ALU and output register SHALL be in arb_alu.

Verification (N_SRC=4, DATA_W=4)
REQ-034 Reset test: rst_n=0 for 2 cycles, all src_valid=1 -> src_ready=0000, out_valid=0, out_data=0.
REQ-035 Fixed-priority test: src1 op10 data E and src3 op01 data F, out_ready=1 -> out 4'hA with out_src=3, then out 4'h1 with out_src=1.
REQ-036 Backpressure test: FULL with out_ready=0 for 3 cycles -> src_ready=0000 and out_data stable; out_ready=1 -> next result loads at the same edge.
REQ-037 Opcode test: op11 data 0111 -> 1100; op00 data 9 -> 0; op10 data D -> 0.
REQ-038 Round-robin test: all 4 sources valid, out_ready=1 -> out_src 0,1,2,3,0 with ARB_ALU_RR_EN, and 3,3,3,3,3 without it.
REQ-039 Mid-operation reset test: rst_n=0 for 1 cycle while FULL -> out_valid=0 next edge; round-robin restarts at source 0.

Source files
------------

// File: rtl/arb_alu_pkg.sv
// Shared opcode constants, output-stage state type and sizing helper for arb_alu.
// Build option ARB_ALU_RR_EN (used by the arbiter) selects round-robin over fixed priority.
package arb_alu_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_ADD3 = 2'b10;
  localparam logic [1:0] OP_SHL2 = 2'b11;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Width of a source index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_alu_arbiter.sv
// Grant selection for arb_alu: fixed highest-index priority by default,
// rotating priority when the macro ARB_ALU_RR_EN is defined.
module arb_alu_arbiter
  import arb_alu_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int IDX_W = idx_width(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_valid,
  input  logic             can_load,
  output logic [N_SRC-1:0] src_ready,
  output logic [IDX_W-1:0] grant_idx
);

  logic any_valid;

  assign any_valid = |src_valid;

`ifdef ARB_ALU_RR_EN
  logic [IDX_W-1:0] last_grant;

  // Search upward from the source after the last winner, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int off = 1; off <= N_SRC; off++) begin
      idx = (int'(last_grant) + off) % N_SRC;
      if (!found && src_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

  // The pointer only moves when a transfer actually happens.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(N_SRC - 1);
    end else if (|src_ready) begin
      last_grant <= grant_idx;
    end
  end
`else
  logic unused_clk;

  assign unused_clk = clk;

  // Ascending scan so the highest-index valid source wins.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_valid[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end
`endif

  assign src_ready = (rst_n && can_load && any_valid) ? (N_SRC'(1) << grant_idx) : '0;

endmodule

// File: rtl/arb_alu.sv
// Arbitrated single-result ALU: one granted source per cycle is computed and
// registered with one-cycle latency. ARB_ALU_RR_EN enables round-robin grant.
module arb_alu
  import arb_alu_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_SRC-1:0]              src_valid,
  input  logic [2*N_SRC-1:0]            src_op,
  input  logic [DATA_W*N_SRC-1:0]       src_data,
  output logic [N_SRC-1:0]              src_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [idx_width(N_SRC)-1:0]   out_src,
  input  logic                          out_ready
);

  localparam int IDX_W = idx_width(N_SRC);

  out_state_e        state_q;
  out_state_e        state_d;
  logic              can_load;
  logic              transfer;
  logic [IDX_W-1:0]  grant_idx;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] alu_result;

  assign can_load  = (state_q == OUT_EMPTY) || out_ready;
  assign transfer  = |(src_ready & src_valid);
  assign out_valid = (state_q == OUT_FULL);

  arb_alu_arbiter #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .can_load  (can_load),
    .src_ready (src_ready),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_op   = src_op[2*i +: 2];
        sel_data = src_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Alternating mask: odd bit positions set.
  always_comb begin
    mask = '0;
    for (int k = 0; k < DATA_W; k++) begin
      mask[k] = 1'(k % 2);
    end
  end

  always_comb begin
    alu_result = '0;
    case (sel_op)
      OP_NOP:  alu_result = '0;
      OP_AND:  alu_result = sel_data & mask;
      OP_ADD3: alu_result = sel_data + DATA_W'(3);
      OP_SHL2: alu_result = sel_data << 2;
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A new transfer always fills; otherwise draining with nothing to load empties.
  always_comb begin
    state_d = state_q;
    if (transfer) begin
      state_d = OUT_FULL;
    end else if (can_load) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= '0;
    end else if (transfer) begin
      out_data <= alu_result;
      out_src  <= grant_idx;
    end
  end

endmodule

// File: tb/tb_arb_alu.sv
// Scoreboard bench for arb_alu (N_SRC=4, DATA_W=4); follows ARB_ALU_RR_EN
// when it is defined so the reference model matches the build.
module tb_arb_alu;

  localparam int N  = 4;
  localparam int DW = 4;

  typedef struct {
    int src;
    int data;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  src_valid;
  logic [2*N-1:0] src_op;
  logic [DW*N-1:0] src_data;
  logic [N-1:0]  src_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_ready;

  exp_t exp_q[$];
  int   m_last;
  int   n_checks;
  int   n_pass;

  arb_alu #(.N_SRC(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_op    (src_op),
    .src_data  (src_data),
    .src_ready (src_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Which source the rules say wins, or -1 when nobody asks.
  function automatic int pick(input logic [N-1:0] v, input int last);
    if (v == '0) return -1;
`ifdef ARB_ALU_RR_EN
    for (int off = 1; off <= N; off++) begin
      if (v[(last + off) % N]) return (last + off) % N;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic int ref_result(input int op, input int data);
    int mask;
    int modulus;
    mask    = 0;
    modulus = 1 << DW;
    for (int k = 0; k < DW; k++) begin
      if (k % 2 == 1) mask += (1 << k);
    end
    case (op)
      0:       return 0;
      1:       return data & mask;
      2:       return (data + 3) % modulus;
      default: return (data * 4) % modulus;
    endcase
  endfunction

  // Drive one cycle of inputs, check src_ready, then update the model at the edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [2*N-1:0] op,
                               input logic [DW*N-1:0] d, input logic rdy, input logic rst);
    int g;
    logic can;
    logic [N-1:0] exp_ready;
    exp_t e;
    src_valid = v;
    src_op    = op;
    src_data  = d;
    out_ready = rdy;
    rst_n     = rst;
    #1;
    can       = (exp_q.size() == 0) || rdy;
    g         = pick(v, m_last);
    exp_ready = '0;
    if (rst && can && g >= 0) exp_ready[g] = 1'b1;
    checkOutput("src_ready", 32'(src_ready), 32'(exp_ready));
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      m_last = N - 1;
    end else if (exp_ready != '0) begin
      e.src  = g;
      e.data = ref_result(int'(op[2*g +: 2]), int'(d[DW*g +: DW]));
      exp_q.push_back(e);
      m_last = g;
    end
    #1;
    if (!rst) begin
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_out_data", 32'(out_data), 32'(0));
      checkOutput("rst_out_src", 32'(out_src), 32'(0));
    end
  endtask

  // Monitor: compare whatever the DUT presents against the head of the queue.
  always @(negedge clk) begin
    checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (out_valid && exp_q.size() != 0) begin
      checkOutput("out_data", 32'(out_data), 32'(exp_q[0].data));
      checkOutput("out_src", 32'(out_src), 32'(exp_q[0].src));
      if (out_ready && rst_n) void'(exp_q.pop_front());
    end
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    m_last    = N - 1;
    rst_n     = 1'b0;
    src_valid = '0;
    src_op    = '0;
    src_data  = '0;
    out_ready = 1'b0;

    // Reset with every source requesting.
    repeat (2) applyStimulus(4'hF, 8'hFF, 16'hFFFF, 1'b1, 1'b0);

    // Source 1: add3 on E, source 3: and on F.
    repeat (2) applyStimulus(4'b1010, 8'b01_00_10_00, 16'hF0E0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 8'h00, 16'h0000, 1'b1, 1'b1);

    // Fill, hold under backpressure, then release with a new source waiting.
    applyStimulus(4'b0100, 8'b00_11_00_00, 16'h0500, 1'b1, 1'b1);
    repeat (3) applyStimulus(4'b1001, 8'b10_00_00_01, 16'h700B, 1'b0, 1'b1);
    applyStimulus(4'b1001, 8'b10_00_00_01, 16'h700B, 1'b1, 1'b1);
    applyStimulus(4'b0000, 8'h00, 16'h0000, 1'b1, 1'b1);

    // Opcode corner values on source 0.
    applyStimulus(4'b0001, 8'b00_00_00_11, 16'h0007, 1'b1, 1'b1);
    applyStimulus(4'b0001, 8'b00_00_00_00, 16'h0009, 1'b1, 1'b1);
    applyStimulus(4'b0001, 8'b00_00_00_10, 16'h000D, 1'b1, 1'b1);

    // All sources valid straight after reset.
    applyStimulus(4'hF, 8'h00, 16'h0000, 1'b1, 1'b0);
    repeat (5) applyStimulus(4'hF, 8'b10_10_10_10, 16'h4321, 1'b1, 1'b1);

    // Reset while a result is held, then resume.
    applyStimulus(4'hF, 8'hE4, 16'h1234, 1'b0, 1'b1);
    applyStimulus(4'hF, 8'hE4, 16'h1234, 1'b0, 1'b0);
    repeat (3) applyStimulus(4'hF, 8'hE4, 16'h1234, 1'b1, 1'b1);

    // Random traffic with occasional backpressure and rare resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(N'($urandom), 8'($urandom), 16'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) != 0));
    end

    // Drain with a bounded budget.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      applyStimulus(4'b0000, 8'h00, 16'h0000, 1'b1, 1'b1);
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
